// File: rtl/frame_tx_d48.sv
// frame_tx_d48 - transmit-side framer for the dual-channel bus comparator.
//
// Takes a 48-bit payload and computes CRC-16 over it one byte per clock:
// polynomial 0x1021, init 0x0000, MSB-first, no reflection, no final XOR.
// The bytes go in the order payload[47:40] first and payload[7:0] last.
// It then emits the frame {payload, crc} with a dataEn strobe.
//
// Ports
//   i_clk           system clock, rising edge
//   i_rst           asynchronous active-high reset
//   i_payloadIn     48-bit payload, sampled on accept
//   i_payloadValid  payload present
//   o_payloadReady  registered ready; accept = valid & ready
//   i_corruptCrc    sampled on accept; 1 inverts crc[0] of the emitted frame
//   o_dataOut       frame {payload[47:0], crc[15:0]}, held until the next frame load
//   o_dataEn        frame-valid strobe, high for EN_WIDTH cycles
//   o_busy          high whenever the FSM is not idle
//   o_frameCnt      count of emitted frames, wraps 0xFFFF -> 0x0000
module frame_tx_d48 #(
  parameter int unsigned EN_WIDTH   = 1,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [47:0] i_payloadIn,
  input  logic        i_payloadValid,
  output logic        o_payloadReady,
  input  logic        i_corruptCrc,
  output logic [63:0] o_dataOut,
  output logic        o_dataEn,
  output logic        o_busy,
  output logic [15:0] o_frameCnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CRC  = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // The IDLE cycle that precedes an accept counts as one of the gap cycles.
  // The GAP state therefore lasts GAP_CYCLES-1 cycles.
  localparam logic [7:0] C_EN_LOAD  = 8'(EN_WIDTH - 1);
  localparam bit         C_USE_GAP  = (GAP_CYCLES > 1);
  localparam logic [7:0] C_GAP_LOAD = C_USE_GAP ? 8'(GAP_CYCLES - 2) : 8'd0;

  // One CRC-16/0x1021 step over a full byte, MSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  state_t      r_state, w_state_nx;
  logic [47:0] r_payload, w_payload_nx;
  logic        r_corrupt, w_corrupt_nx;
  logic [15:0] r_crc, w_crc_nx;
  logic [2:0]  r_byte_idx, w_byte_idx_nx;
  logic [7:0]  r_cnt, w_cnt_nx;
  logic [63:0] r_data_out, w_data_out_nx;
  logic        r_data_en, w_data_en_nx;
  logic [15:0] r_frame_cnt, w_frame_cnt_nx;
  logic        r_ready, r_busy;
  logic        w_accept;
  logic [7:0]  w_byte;

  assign w_accept = i_payloadValid & r_ready;

  // Select the payload byte for the current CRC step.
  always_comb begin
    w_byte = 8'h00;
    case (r_byte_idx)
      3'd0:    w_byte = r_payload[47:40];
      3'd1:    w_byte = r_payload[39:32];
      3'd2:    w_byte = r_payload[31:24];
      3'd3:    w_byte = r_payload[23:16];
      3'd4:    w_byte = r_payload[15:8];
      3'd5:    w_byte = r_payload[7:0];
      default: w_byte = 8'h00;
    endcase
  end

  // Next-state and next-datapath logic for the framer FSM.
  always_comb begin
    w_state_nx     = r_state;
    w_payload_nx   = r_payload;
    w_corrupt_nx   = r_corrupt;
    w_crc_nx       = r_crc;
    w_byte_idx_nx  = r_byte_idx;
    w_cnt_nx       = r_cnt;
    w_data_out_nx  = r_data_out;
    w_data_en_nx   = r_data_en;
    w_frame_cnt_nx = r_frame_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_payload_nx  = i_payloadIn;
          w_corrupt_nx  = i_corruptCrc;
          w_crc_nx      = 16'h0000;
          w_byte_idx_nx = 3'd0;
          w_state_nx    = ST_CRC;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_CRC: begin
        if (r_byte_idx < 3'd6) begin
          w_crc_nx      = crc16_byte(r_crc, w_byte);
          w_byte_idx_nx = r_byte_idx + 3'd1;
        end else begin
          w_data_out_nx  = {r_payload, r_crc ^ {15'd0, r_corrupt}};
          w_data_en_nx   = 1'b1;
          w_frame_cnt_nx = r_frame_cnt + 16'd1;
          w_cnt_nx       = C_EN_LOAD;
          w_state_nx     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (r_cnt == 8'd0) begin
          w_data_en_nx = 1'b0;
          if (C_USE_GAP) begin
            w_cnt_nx   = C_GAP_LOAD;
            w_state_nx = ST_GAP;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end else begin
          w_cnt_nx = r_cnt - 8'd1;
        end
      end
      ST_GAP: begin
        if (r_cnt == 8'd0) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_cnt_nx = r_cnt - 8'd1;
        end
      end
      default: begin
        w_data_en_nx = 1'b0;
        w_state_nx   = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Datapath and output registers.
  // Ready and busy are derived from the next state, so they line up with r_state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_payload   <= 48'd0;
      r_corrupt   <= 1'b0;
      r_crc       <= 16'h0000;
      r_byte_idx  <= 3'd0;
      r_cnt       <= 8'd0;
      r_data_out  <= 64'd0;
      r_data_en   <= 1'b0;
      r_frame_cnt <= 16'd0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_payload   <= w_payload_nx;
      r_corrupt   <= w_corrupt_nx;
      r_crc       <= w_crc_nx;
      r_byte_idx  <= w_byte_idx_nx;
      r_cnt       <= w_cnt_nx;
      r_data_out  <= w_data_out_nx;
      r_data_en   <= w_data_en_nx;
      r_frame_cnt <= w_frame_cnt_nx;
      r_ready     <= (w_state_nx == ST_IDLE);
      r_busy      <= (w_state_nx != ST_IDLE);
    end
  end

  assign o_payloadReady = r_ready;
  assign o_dataOut      = r_data_out;
  assign o_dataEn       = r_data_en;
  assign o_busy         = r_busy;
  assign o_frameCnt     = r_frame_cnt;

endmodule

// File: tb/tb_frame_tx_d48.sv
// Testbench for frame_tx_d48 with EN_WIDTH=1 and GAP_CYCLES=4.
// The bench drives inputs on the falling edge and samples outputs 1 time unit after the rising edge.
module tb_frame_tx_d48;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] payload_in;
  logic        payload_valid;
  logic        payload_ready;
  logic        corrupt_crc;
  logic [63:0] data_out;
  logic        data_en;
  logic        busy;
  logic [15:0] frame_cnt;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_cnt  = 16'd0;

  frame_tx_d48 #(.EN_WIDTH(1), .GAP_CYCLES(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_payloadIn    (payload_in),
    .i_payloadValid (payload_valid),
    .o_payloadReady (payload_ready),
    .i_corruptCrc   (corrupt_crc),
    .o_dataOut      (data_out),
    .o_dataEn       (data_en),
    .o_busy         (busy),
    .o_frameCnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  // Bit-serial reference CRC over the low nbits of d, MSB first.
  function automatic logic [15:0] ref_crc(input logic [63:0] d, input int nbits);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int i = nbits - 1; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  // Wait for ready, present one payload, and then scramble the inputs after the accept edge.
  task automatic accept_frame(input logic [47:0] p, input logic c, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (payload_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (payload_ready === 1'b1);
    if (ok) begin
      payload_in    = p;
      corrupt_crc   = c;
      payload_valid = 1'b1;
      @(posedge clk);
      #1;
      payload_valid = 1'b0;
      payload_in    = ~p;
      corrupt_crc   = ~c;
    end else begin
      payload_valid = 1'b0;
    end
  endtask

  // Accept one frame and capture the rise latency, the frame, the count and the cycle after.
  task automatic run_frame(input logic [47:0] p, input logic c, output int lat,
                           output logic [63:0] dat, output logic [15:0] cnt,
                           output logic en_after, output logic [63:0] dat_after);
    bit ok;
    lat = -1; dat = 64'd0; cnt = 16'd0; en_after = 1'bx; dat_after = 64'd0;
    accept_frame(p, c, ok);
    if (ok) begin
      for (int i = 1; i <= 40; i++) begin
        @(posedge clk);
        #1;
        if (data_en === 1'b1) begin
          lat = i;
          break;
        end
      end
      dat = data_out;
      cnt = frame_cnt;
      @(posedge clk);
      #1;
      en_after  = data_en;
      dat_after = data_out;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; payload_valid = 1'b1; payload_in = 48'hFFFF_FFFF_FFFF; corrupt_crc = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (data_out !== 64'd0) begin failures++; $display("FAIL reset_dataOut got=%h exp=%h", data_out, 64'd0); end
    checks++; if (data_en !== 1'b0) begin failures++; $display("FAIL reset_dataEn got=%b exp=0", data_en); end
    checks++; if (payload_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", payload_ready); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frameCnt got=%h exp=0000", frame_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    payload_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (payload_ready !== 1'b1) begin failures++; $display("FAIL ready_after_release got=%b exp=1", payload_ready); end
  endtask

  task automatic test_zero_payload();
    int lat; logic [63:0] d, da; logic [15:0] c; logic ea;
    run_frame(48'h0, 1'b0, lat, d, c, ea, da);
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (lat != 7) begin failures++; $display("FAIL zero_latency got=%0d exp=7", lat); end
    checks++; if (d !== 64'h0000_0000_0000_0000) begin failures++; $display("FAIL zero_data got=%h exp=%h", d, 64'h0); end
    checks++; if (c !== exp_cnt) begin failures++; $display("FAIL zero_frameCnt got=%h exp=%h", c, exp_cnt); end
    checks++; if (ea !== 1'b0) begin failures++; $display("FAIL zero_en_width got=%b exp=0", ea); end
  endtask

  task automatic test_single_bit();
    int lat; logic [63:0] d, da; logic [15:0] c; logic ea;
    run_frame(48'h0000_0000_0001, 1'b0, lat, d, c, ea, da);
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (d !== 64'h0000_0000_0001_1021) begin failures++; $display("FAIL bit_data got=%h exp=%h", d, 64'h0000_0000_0001_1021); end
    checks++; if (da !== 64'h0000_0000_0001_1021) begin failures++; $display("FAIL bit_data_hold got=%h exp=%h", da, 64'h0000_0000_0001_1021); end
    checks++; if (c !== exp_cnt) begin failures++; $display("FAIL bit_frameCnt got=%h exp=%h", c, exp_cnt); end
    run_frame(48'h0000_0000_0001, 1'b1, lat, d, c, ea, da);
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (d !== 64'h0000_0000_0001_1020) begin failures++; $display("FAIL corrupt_data got=%h exp=%h", d, 64'h0000_0000_0001_1020); end
    checks++; if (lat != 7) begin failures++; $display("FAIL corrupt_latency got=%0d exp=7", lat); end
  endtask

  task automatic test_back_to_back();
    logic [47:0] pa, pb;
    logic [63:0] ea_exp, eb_exp, da, db;
    int r1, r2, n;
    logic prev, seen_ready;
    pa = 48'h1234_5678_9ABC;
    pb = 48'hFEDC_BA98_7654;
    ea_exp = {pa, ref_crc({16'h0, pa}, 48)};
    eb_exp = {pb, ref_crc({16'h0, pb}, 48)};
    r1 = -1; r2 = -1; prev = 1'b0; seen_ready = 1'b0; da = 64'd0; db = 64'd0;
    n = 0;
    @(negedge clk);
    while (payload_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    payload_in = pa; corrupt_crc = 1'b0; payload_valid = 1'b1;
    @(posedge clk); #1;
    payload_in = pb;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (seen_ready) begin payload_valid = 1'b0; seen_ready = 1'b0; end
      if (data_en === 1'b1 && prev === 1'b0) begin
        if (r1 < 0) begin r1 = i; da = data_out; end
        else if (r2 < 0) begin r2 = i; db = data_out; end
      end
      if (r1 >= 0 && r2 < 0 && payload_valid && payload_ready === 1'b1) seen_ready = 1'b1;
      prev = data_en;
    end
    payload_valid = 1'b0;
    exp_cnt = exp_cnt + 16'd2;
    checks++; if (r1 != 7) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=7", r1); end
    checks++; if (r2 - r1 != 12) begin failures++; $display("FAIL b2b_spacing got=%0d exp=12", r2 - r1); end
    checks++; if (da !== ea_exp) begin failures++; $display("FAIL b2b_frame1 got=%h exp=%h", da, ea_exp); end
    checks++; if (db !== eb_exp) begin failures++; $display("FAIL b2b_frame2 got=%h exp=%h", db, eb_exp); end
    checks++; if (frame_cnt !== exp_cnt) begin failures++; $display("FAIL b2b_frameCnt got=%h exp=%h", frame_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid_crc();
    bit ok; bit saw_en;
    accept_frame(48'hABCD_EF01_2345, 1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL midrst_accept got=0 exp=1"); end
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (data_out !== 64'd0 || data_en !== 1'b0 || frame_cnt !== 16'd0 || payload_ready !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL midrst_outputs got=%h/%b/%h/%b/%b exp=0/0/0000/0/0", data_out, data_en, frame_cnt, payload_ready, busy);
    end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    exp_cnt = 16'd0;
    saw_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (data_en !== 1'b0) saw_en = 1'b1;
    end
    checks++; if (saw_en) begin failures++; $display("FAIL midrst_late_en got=1 exp=0"); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL midrst_frameCnt got=%h exp=0000", frame_cnt); end
  endtask

  task automatic test_wrap();
    int lat, n; logic [63:0] d, da, e; logic [15:0] c; logic ea;
    n = 0;
    @(negedge clk);
    while (payload_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    force dut.r_frame_cnt = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.r_frame_cnt;
    checks++; if (frame_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=ffff", frame_cnt); end
    e = {48'h0000_0000_00FF, ref_crc({16'h0, 48'h0000_0000_00FF}, 48)};
    run_frame(48'h0000_0000_00FF, 1'b0, lat, d, c, ea, da);
    exp_cnt = 16'h0000;
    checks++; if (c !== exp_cnt) begin failures++; $display("FAIL wrap_frameCnt got=%h exp=%h", c, exp_cnt); end
    checks++; if (d !== e) begin failures++; $display("FAIL wrap_data got=%h exp=%h", d, e); end
  endtask

  task automatic test_loopback();
    int lat; logic [63:0] d, da, e; logic [15:0] c; logic ea;
    logic [31:0] a, b; logic [47:0] p; logic cc; bit rx_ok;
    for (int k = 0; k < 1000; k++) begin
      a = $urandom; b = $urandom;
      p = {a[15:0], b};
      cc = ($urandom_range(0, 3) == 0);
      e = {p, ref_crc({16'h0, p}, 48) ^ {15'd0, cc}};
      run_frame(p, cc, lat, d, c, ea, da);
      exp_cnt = exp_cnt + 16'd1;
      rx_ok = (ref_crc(d, 64) == 16'h0000);
      checks++; if (d !== e || lat != 7) begin failures++; $display("FAIL loop_frame k=%0d got=%h lat=%0d exp=%h lat=7", k, d, lat, e); end
      checks++; if (rx_ok == cc) begin failures++; $display("FAIL loop_rxcrc k=%0d got_pass=%0d exp_pass=%0d", k, rx_ok, !cc); end
    end
    checks++; if (frame_cnt !== exp_cnt) begin failures++; $display("FAIL loop_frameCnt got=%h exp=%h", frame_cnt, exp_cnt); end
  endtask

  initial begin
    rst = 1'b1; payload_valid = 1'b0; payload_in = 48'd0; corrupt_crc = 1'b0;
    test_reset();
    test_zero_payload();
    test_single_bit();
    test_back_to_back();
    test_reset_mid_crc();
    test_wrap();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
